// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle MULT/MULTU/DIV/DIVU sequencer:
// opcode encoding, FSM state encoding and iteration-counter sizing.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_PREP = S_PREP,
    ST_ITER = S_ITER,
    ST_FIX  = S_FIX,
    ST_DONE = S_DONE
  } state_e;

  localparam int MD_WIDTH = 32;
  localparam int CNT_W    = $clog2(MD_WIDTH + 1);

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute stage and the mul/div sequencer.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/muldiv_addsub.sv
// Combinational add/subtract shared by the multiply and divide iterations.
// co_o is the carry-out when adding and the borrow when subtracting.
module muldiv_addsub #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             co_o
);

  logic [WIDTH:0]   full;
  logic [WIDTH-1:0] y_eff;

  assign y_eff = sub_i ? ~y_i : y_i;
  assign full  = {1'b0, x_i} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub_i};
  assign sum_o = full[WIDTH-1:0];
  assign co_o  = sub_i ? ~full[WIDTH] : full[WIDTH];

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MIPS multiply/divide unit: shift-add multiply and restoring divide
// over WIDTH cycles, sharing one (WIDTH+1)-bit adder, results in HI/LO.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  md
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic             is_div, is_signed;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   as_x, as_y, as_sum;
  logic             as_co;
  logic [WIDTH:0]   div_sh, mul_acc;
  logic [WIDTH-1:0] div_rem;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0] lo_neg, hi_neg;

  assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);

  assign a_abs = (is_signed && a_q[WIDTH-1]) ? (~a_q + WIDTH'(1)) : a_q;
  assign b_abs = (is_signed && b_q[WIDTH-1]) ? (~b_q + WIDTH'(1)) : b_q;

  // Divide sees the left-shifted remainder including the bit shifted out of hi,
  // so divisors with the top bit set still compare correctly.
  assign div_sh = {hi_q, lo_q[WIDTH-1]};
  assign as_x   = is_div ? div_sh : {1'b0, hi_q};
  assign as_y   = {1'b0, y_q};

  muldiv_addsub #(.WIDTH(WIDTH + 1)) u_addsub (
    .x_i   (as_x),
    .y_i   (as_y),
    .sub_i (is_div),
    .sum_o (as_sum),
    .co_o  (as_co)
  );

  assign mul_acc  = lo_q[0] ? as_sum : {1'b0, hi_q};
  assign div_rem  = as_co ? div_sh[WIDTH-1:0] : as_sum[WIDTH-1:0];
  assign prod_neg = ~{hi_q, lo_q} + (2*WIDTH)'(1);
  assign lo_neg   = ~lo_q + WIDTH'(1);
  assign hi_neg   = ~hi_q + WIDTH'(1);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (md.start) begin
          op_d    = md.op;
          a_d     = md.a;
          b_d     = md.b;
          state_d = ST_PREP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PREP: begin
        qneg_d = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rneg_d = is_signed & a_q[WIDTH-1];
        cnt_d  = '0;
        hi_d   = '0;
        if (is_div) begin
          y_d  = b_abs;
          lo_d = a_abs;
          if (b_q == '0) begin
            hi_d    = a_q;
            lo_d    = '1;
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_ITER;
          end
        end else begin
          y_d     = a_abs;
          lo_d    = b_abs;
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div) begin
          hi_d = div_rem;
          lo_d = {lo_q[WIDTH-2:0], ~as_co};
        end else begin
          hi_d = mul_acc[WIDTH:1];
          lo_d = {mul_acc[0], lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        // Sign flags are already zero for unsigned ops.
        if (is_div) begin
          if (qneg_q) lo_d = lo_neg;
          if (rneg_q) hi_d = hi_neg;
        end else if (qneg_q) begin
          {hi_d, lo_d} = prod_neg;
        end
        dz_d    = 1'b0;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q   <= op_d;
    a_q    <= a_d;
    b_q    <= b_d;
    y_q    <= y_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
  end

  assign md.busy     = (state_q == ST_PREP) || (state_q == ST_ITER) || (state_q == ST_FIX);
  assign md.done     = (state_q == ST_DONE);
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: reset, multiply, divide, divide-by-zero,
// ignored mid-operation start, mid-operation reset and back-to-back operation.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  muldiv_if #(.WIDTH(32)) md ();

  muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int edges, output int busy_cycles);
    md.start = 1'b1;
    md.op    = op;
    md.a     = a;
    md.b     = b;
    @(posedge clk); #1;
    md.start    = 1'b0;
    edges       = 1;
    busy_cycles = 0;
    while (md.done !== 1'b1 && edges < 100) begin
      if (md.busy === 1'b1) busy_cycles++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    md.start = 1'b0; md.op = 2'b00; md.a = '0; md.b = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (md.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", md.busy); end
    checks++; if (md.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", md.done); end
    checks++; if (md.div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b expected 0", md.div_zero); end
    checks++; if (md.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", md.hi); end
    checks++; if (md.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 0", md.lo); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_multu();
    int e, bc;
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, e, bc);
    checks++; if (e !== 35) begin errors++; $display("FAIL multu_latency: got %0d edges expected 35", e); end
    checks++; if (bc !== 34) begin errors++; $display("FAIL multu_busy: got %0d cycles expected 34", bc); end
    checks++; if (md.hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h expected fffffffe", md.hi); end
    checks++; if (md.lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h expected 00000001", md.lo); end
    checks++; if (md.div_zero !== 1'b0) begin errors++; $display("FAIL multu_dz: got %b expected 0", md.div_zero); end
    @(posedge clk); #1;
    checks++; if (md.done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b expected 0", md.done); end
    checks++; if (md.lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo_hold: got %h expected 00000001", md.lo); end
  endtask

  task automatic test_mult();
    int e, bc;
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, e, bc);
    checks++; if (md.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_neg_hi: got %h expected ffffffff", md.hi); end
    checks++; if (md.lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_neg_lo: got %h expected ffffffeb", md.lo); end
    run_op(OP_MULT, 32'h80000000, 32'h80000000, e, bc);
    checks++; if (md.hi !== 32'h40000000) begin errors++; $display("FAIL mult_min_hi: got %h expected 40000000", md.hi); end
    checks++; if (md.lo !== 32'h00000000) begin errors++; $display("FAIL mult_min_lo: got %h expected 00000000", md.lo); end
    run_op(OP_MULT, 32'hFFFFFFFD, 32'hFFFFFFF9, e, bc);
    checks++; if ({md.hi, md.lo} !== 64'd21) begin errors++; $display("FAIL mult_negneg: got %h%h expected 21", md.hi, md.lo); end
  endtask

  task automatic test_div();
    int e, bc;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, e, bc);
    checks++; if (e !== 35) begin errors++; $display("FAIL div_latency: got %0d edges expected 35", e); end
    checks++; if (md.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_lo: got %h expected fffffffd", md.lo); end
    checks++; if (md.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_hi: got %h expected ffffffff", md.hi); end
    run_op(OP_DIVU, 32'd7, 32'd2, e, bc);
    checks++; if (md.lo !== 32'd3) begin errors++; $display("FAIL divu_lo: got %h expected 3", md.lo); end
    checks++; if (md.hi !== 32'd1) begin errors++; $display("FAIL divu_hi: got %h expected 1", md.hi); end
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, e, bc);
    checks++; if (md.lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo: got %h expected 80000000", md.lo); end
    checks++; if (md.hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h expected 0", md.hi); end
    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, e, bc);
    checks++; if (md.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_negdiv_lo: got %h expected fffffffd", md.lo); end
    checks++; if (md.hi !== 32'd1) begin errors++; $display("FAIL div_negdiv_hi: got %h expected 1", md.hi); end
    run_op(OP_DIVU, 32'hFFFFFFFF, 32'h80000000, e, bc);
    checks++; if (md.lo !== 32'd1) begin errors++; $display("FAIL divu_big_lo: got %h expected 1", md.lo); end
    checks++; if (md.hi !== 32'h7FFFFFFF) begin errors++; $display("FAIL divu_big_hi: got %h expected 7fffffff", md.hi); end
  endtask

  task automatic test_div_zero();
    int e, bc;
    run_op(OP_DIVU, 32'd5, 32'd0, e, bc);
    checks++; if (e !== 2) begin errors++; $display("FAIL dz_latency: got %0d edges expected 2", e); end
    checks++; if (bc !== 1) begin errors++; $display("FAIL dz_busy: got %0d cycles expected 1", bc); end
    checks++; if (md.div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", md.div_zero); end
    checks++; if (md.hi !== 32'd5) begin errors++; $display("FAIL dz_hi: got %h expected 5", md.hi); end
    checks++; if (md.lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz_lo: got %h expected ffffffff", md.lo); end
    @(posedge clk); #1;
    checks++; if (md.div_zero !== 1'b1) begin errors++; $display("FAIL dz_hold: got %b expected 1", md.div_zero); end
    run_op(OP_MULTU, 32'd2, 32'd3, e, bc);
    checks++; if (md.div_zero !== 1'b0) begin errors++; $display("FAIL dz_clear: got %b expected 0", md.div_zero); end
    checks++; if (md.lo !== 32'd6) begin errors++; $display("FAIL dz_next_lo: got %h expected 6", md.lo); end
    checks++; if (md.hi !== 32'd0) begin errors++; $display("FAIL dz_next_hi: got %h expected 0", md.hi); end
  endtask

  task automatic test_start_ignored();
    int e;
    md.start = 1'b1; md.op = OP_MULTU; md.a = 32'd1000; md.b = 32'd1000;
    @(posedge clk); #1;
    md.start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    md.start = 1'b1; md.op = OP_DIVU; md.a = 32'd1; md.b = 32'd1;
    @(posedge clk); #1;
    md.start = 1'b0;
    e = 12;
    while (md.done !== 1'b1 && e < 100) begin @(posedge clk); #1; e++; end
    checks++; if (e !== 35) begin errors++; $display("FAIL ignore_latency: got %0d edges expected 35", e); end
    checks++; if (md.lo !== 32'h000F4240) begin errors++; $display("FAIL ignore_lo: got %h expected 000f4240", md.lo); end
    checks++; if (md.hi !== 32'h0) begin errors++; $display("FAIL ignore_hi: got %h expected 0", md.hi); end
  endtask

  task automatic test_reset_mid();
    int seen;
    md.start = 1'b1; md.op = OP_MULTU; md.a = 32'hFFFFFFFF; md.b = 32'hFFFFFFFF;
    @(posedge clk); #1;
    md.start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (md.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", md.busy); end
    checks++; if (md.hi !== 32'h0) begin errors++; $display("FAIL rstmid_hi: got %h expected 0", md.hi); end
    checks++; if (md.lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo: got %h expected 0", md.lo); end
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (md.done === 1'b1 || md.busy === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    int e, bc;
    run_op(OP_MULTU, 32'd2, 32'd3, e, bc);
    checks++; if (md.lo !== 32'd6) begin errors++; $display("FAIL b2b_first_lo: got %h expected 6", md.lo); end
    run_op(OP_DIVU, 32'd100, 32'd7, e, bc);
    checks++; if (e !== 35) begin errors++; $display("FAIL b2b_latency: got %0d edges expected 35", e); end
    checks++; if (bc !== 34) begin errors++; $display("FAIL b2b_busy: got %0d cycles expected 34", bc); end
    checks++; if (md.lo !== 32'd14) begin errors++; $display("FAIL b2b_lo: got %h expected 0000000e", md.lo); end
    checks++; if (md.hi !== 32'd2) begin errors++; $display("FAIL b2b_hi: got %h expected 2", md.hi); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
